// File: rtl/nb_dcache.sv
// Non-blocking set-associative write-back data cache with a small MSHR file.
// Hits complete in one cycle; misses take an MSHR that writes back the victim and then refills the line.
module nb_dcache #(
    parameter int N_SETS     = 4,
    parameter int N_WAYS     = 2,
    parameter int N_ELEMENTS = 4,
    parameter int N_BYTES    = 4,
    parameter int PA_WIDTH   = 16,
    parameter int N_MSHR     = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_req_valid,
    input  logic                             i_req_we,
    input  logic [PA_WIDTH-1:0]              i_req_addr,
    input  logic [N_BYTES-1:0]               i_req_be,
    input  logic [N_BYTES*8-1:0]             i_req_wdata,
    output logic                             o_req_ready,
    output logic                             o_rsp_valid,
    output logic [N_BYTES*8-1:0]             o_rsp_data,
    output logic                             o_mem_req_valid,
    input  logic                             i_mem_req_ready,
    output logic                             o_mem_req_we,
    output logic [PA_WIDTH-1:0]              o_mem_req_addr,
    output logic [N_ELEMENTS*N_BYTES*8-1:0]  o_mem_req_data,
    output logic [$clog2(N_MSHR)-1:0]        o_mem_req_id,
    input  logic                             i_mem_rsp_valid,
    input  logic [$clog2(N_MSHR)-1:0]        i_mem_rsp_id,
    input  logic [N_ELEMENTS*N_BYTES*8-1:0]  i_mem_rsp_data
);
    localparam int OFF_W = $clog2(N_ELEMENTS);
    localparam int SET_W = $clog2(N_SETS);
    localparam int TAG_W = PA_WIDTH - OFF_W - SET_W;
    localparam int WAY_W = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
    localparam int ID_W  = $clog2(N_MSHR);
    localparam int EW    = N_BYTES * 8;
    localparam int LW    = N_ELEMENTS * EW;

    typedef enum logic [1:0] {MS_FREE, MS_WB, MS_RD, MS_WAIT} mshr_st_t;

    logic             valid_q [N_SETS][N_WAYS];
    logic             dirty_q [N_SETS][N_WAYS];
    logic [TAG_W-1:0] tag_q   [N_SETS][N_WAYS];
    logic [LW-1:0]    data_q  [N_SETS][N_WAYS];
    logic [WAY_W-1:0] rr_q    [N_SETS];

    mshr_st_t           ms_st_q    [N_MSHR];
    mshr_st_t           ms_st_d    [N_MSHR];
    logic [TAG_W-1:0]   ms_tag_q   [N_MSHR];
    logic [SET_W-1:0]   ms_set_q   [N_MSHR];
    logic [WAY_W-1:0]   ms_way_q   [N_MSHR];
    logic               ms_we_q    [N_MSHR];
    logic [OFF_W-1:0]   ms_off_q   [N_MSHR];
    logic [N_BYTES-1:0] ms_be_q    [N_MSHR];
    logic [EW-1:0]      ms_wdata_q [N_MSHR];
    logic [TAG_W-1:0]   ms_vtag_q  [N_MSHR];
    logic [LW-1:0]      ms_vdata_q [N_MSHR];

    logic [OFF_W-1:0] req_off;
    logic [SET_W-1:0] req_set;
    logic [TAG_W-1:0] req_tag;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim;
    logic             any_free;
    logic [ID_W-1:0]  free_id;
    logic             line_busy;
    logic             set_busy;
    logic             issue_any;
    logic [ID_W-1:0]  issue_id;
    logic             hold_q;
    logic [ID_W-1:0]  hold_id_q;
    logic             accept;
    logic             alloc;
    logic             mem_hs;
    logic             fill_hit;
    logic [LW-1:0]    fill_line;
    logic [LW-1:0]    store_line;

    assign req_off = i_req_addr[OFF_W-1:0];
    assign req_set = i_req_addr[OFF_W +: SET_W];
    assign req_tag = i_req_addr[PA_WIDTH-1 -: TAG_W];
    assign victim  = rr_q[req_set];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < N_WAYS; w++) begin
            if (valid_q[req_set][w] && tag_q[req_set][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Descending scans leave the lowest matching index selected.
    always_comb begin
        any_free  = 1'b0;
        free_id   = '0;
        line_busy = 1'b0;
        set_busy  = 1'b0;
        issue_any = 1'b0;
        issue_id  = '0;
        for (int m = N_MSHR - 1; m >= 0; m--) begin
            if (ms_st_q[m] == MS_FREE) begin
                any_free = 1'b1;
                free_id  = ID_W'(m);
            end else if (ms_set_q[m] == req_set) begin
                set_busy = 1'b1;
                if (ms_tag_q[m] == req_tag) line_busy = 1'b1;
            end
            if (ms_st_q[m] == MS_WB || ms_st_q[m] == MS_RD) begin
                issue_any = 1'b1;
                issue_id  = ID_W'(m);
            end
        end
        // A stalled memory request keeps its slot even if a lower MSHR became eligible.
        if (hold_q) begin
            issue_any = 1'b1;
            issue_id  = hold_id_q;
        end
    end

    assign o_req_ready = !i_mem_rsp_valid && !line_busy && (hit || (any_free && !set_busy));
    assign accept      = i_req_valid && o_req_ready;
    assign alloc       = accept && !hit;
    assign mem_hs      = issue_any && i_mem_req_ready;
    assign fill_hit    = i_mem_rsp_valid && ms_st_q[i_mem_rsp_id] == MS_WAIT;

    assign o_mem_req_valid = issue_any;
    assign o_mem_req_we    = issue_any && ms_st_q[issue_id] == MS_WB;
    assign o_mem_req_id    = issue_any ? issue_id : '0;
    assign o_mem_req_data  = o_mem_req_we ? ms_vdata_q[issue_id] : '0;
    always_comb begin
        o_mem_req_addr = '0;
        if (o_mem_req_we)
            o_mem_req_addr = {ms_vtag_q[issue_id], ms_set_q[issue_id], {OFF_W{1'b0}}};
        else if (issue_any)
            o_mem_req_addr = {ms_tag_q[issue_id], ms_set_q[issue_id], {OFF_W{1'b0}}};
    end

    always_comb begin
        fill_line = i_mem_rsp_data;
        if (ms_we_q[i_mem_rsp_id]) begin
            for (int b = 0; b < N_BYTES; b++) begin
                if (ms_be_q[i_mem_rsp_id][b])
                    fill_line[(int'(ms_off_q[i_mem_rsp_id]) * N_BYTES + b) * 8 +: 8] =
                        ms_wdata_q[i_mem_rsp_id][b*8 +: 8];
            end
        end
    end

    always_comb begin
        store_line = data_q[req_set][hit_way];
        for (int b = 0; b < N_BYTES; b++) begin
            if (i_req_be[b])
                store_line[(int'(req_off) * N_BYTES + b) * 8 +: 8] = i_req_wdata[b*8 +: 8];
        end
    end

    // Allocation, memory handshake and fill always touch distinct MSHRs.
    always_comb begin
        for (int m = 0; m < N_MSHR; m++) ms_st_d[m] = ms_st_q[m];
        if (mem_hs)
            ms_st_d[issue_id] = (ms_st_q[issue_id] == MS_WB) ? MS_RD : MS_WAIT;
        if (alloc)
            ms_st_d[free_id] = (valid_q[req_set][victim] && dirty_q[req_set][victim]) ? MS_WB : MS_RD;
        if (fill_hit)
            ms_st_d[i_mem_rsp_id] = MS_FREE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < N_MSHR; m++) ms_st_q[m] <= MS_FREE;
            hold_q      <= 1'b0;
            hold_id_q   <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
        end else begin
            for (int m = 0; m < N_MSHR; m++) ms_st_q[m] <= ms_st_d[m];
            hold_q      <= issue_any && !i_mem_req_ready;
            hold_id_q   <= issue_id;
            o_rsp_valid <= 1'b0;
            if (fill_hit && !ms_we_q[i_mem_rsp_id]) begin
                o_rsp_valid <= 1'b1;
                o_rsp_data  <= i_mem_rsp_data[int'(ms_off_q[i_mem_rsp_id]) * EW +: EW];
            end else if (accept && hit && !i_req_we) begin
                o_rsp_valid <= 1'b1;
                o_rsp_data  <= data_q[req_set][hit_way][int'(req_off) * EW +: EW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < N_SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < N_WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                end
            end
        end else if (fill_hit) begin
            valid_q[ms_set_q[i_mem_rsp_id]][ms_way_q[i_mem_rsp_id]] <= 1'b1;
            dirty_q[ms_set_q[i_mem_rsp_id]][ms_way_q[i_mem_rsp_id]] <= ms_we_q[i_mem_rsp_id];
        end else if (accept && hit) begin
            if (i_req_we) dirty_q[req_set][hit_way] <= 1'b1;
        end else if (alloc) begin
            valid_q[req_set][victim] <= 1'b0;
            rr_q[req_set] <= (victim == WAY_W'(N_WAYS - 1)) ? '0 : victim + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_hit) begin
            data_q[ms_set_q[i_mem_rsp_id]][ms_way_q[i_mem_rsp_id]] <= fill_line;
            tag_q[ms_set_q[i_mem_rsp_id]][ms_way_q[i_mem_rsp_id]]  <= ms_tag_q[i_mem_rsp_id];
        end else if (accept && hit && i_req_we) begin
            data_q[req_set][hit_way] <= store_line;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            ms_tag_q[free_id]   <= req_tag;
            ms_set_q[free_id]   <= req_set;
            ms_way_q[free_id]   <= victim;
            ms_we_q[free_id]    <= i_req_we;
            ms_off_q[free_id]   <= req_off;
            ms_be_q[free_id]    <= i_req_be;
            ms_wdata_q[free_id] <= i_req_wdata;
            ms_vtag_q[free_id]  <= tag_q[req_set][victim];
            ms_vdata_q[free_id] <= data_q[req_set][victim];
        end
    end
endmodule

// File: tb/tb_nb_dcache.sv
// Bench for nb_dcache: directed sequences with literal expectations, then random
// traffic checked against a flat-memory behavioural model of the cache.
module tb_nb_dcache;
    localparam int N_SETS = 4, N_WAYS = 2, N_ELEMENTS = 4, N_BYTES = 4, PA_WIDTH = 16, N_MSHR = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_we;
    logic [15:0]  req_addr;
    logic [3:0]   req_be;
    logic [31:0]  req_wdata;
    logic         o_req_ready, o_rsp_valid;
    logic [31:0]  o_rsp_data;
    logic         o_mem_req_valid, mem_ready, o_mem_req_we;
    logic [15:0]  o_mem_req_addr;
    logic [127:0] o_mem_req_data;
    logic [0:0]   o_mem_req_id;
    logic         rsp_valid;
    logic [0:0]   rsp_id;
    logic [127:0] rsp_data;

    int checks = 0;
    int failures = 0;

    nb_dcache #(.N_SETS(N_SETS), .N_WAYS(N_WAYS), .N_ELEMENTS(N_ELEMENTS), .N_BYTES(N_BYTES),
                .PA_WIDTH(PA_WIDTH), .N_MSHR(N_MSHR)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .i_req_we(req_we), .i_req_addr(req_addr),
        .i_req_be(req_be), .i_req_wdata(req_wdata),
        .o_req_ready(o_req_ready), .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
        .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(mem_ready),
        .o_mem_req_we(o_mem_req_we), .o_mem_req_addr(o_mem_req_addr),
        .o_mem_req_data(o_mem_req_data), .o_mem_req_id(o_mem_req_id),
        .i_mem_rsp_valid(rsp_valid), .i_mem_rsp_id(rsp_id), .i_mem_rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int   st;      // 0 free, 1 writeback pending, 2 read pending, 3 waiting for fill
        int   line;
        int   vline;
        int   set;
        int   way;
        bit   we;
        int   addr;
    } ms_t;

    bit           m_valid [N_SETS][N_WAYS];
    bit           m_dirty [N_SETS][N_WAYS];
    int           m_tag   [N_SETS][N_WAYS];
    int           m_rr    [N_SETS];
    ms_t          ms      [N_MSHR];
    bit           m_hold;
    int           m_hold_id;
    bit           exp_rsp;
    logic [31:0]  exp_rsp_data;
    logic [31:0]  golden [int];
    logic [31:0]  mem    [int];

    function automatic logic [31:0] init_val(input int a);
        return 32'(a) * 32'h9E3779B1 + 32'h1234_5678;
    endfunction

    function automatic logic [31:0] gget(input int a);
        return golden.exists(a) ? golden[a] : init_val(a);
    endfunction

    function automatic logic [31:0] mget(input int a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction

    function automatic logic [127:0] gline(input int line);
        logic [127:0] r;
        for (int e = 0; e < 4; e++) r[e*32 +: 32] = gget(line * 4 + e);
        return r;
    endfunction

    function automatic logic [127:0] mline(input int line);
        logic [127:0] r;
        for (int e = 0; e < 4; e++) r[e*32 +: 32] = mget(line * 4 + e);
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < N_SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < N_WAYS; w++) begin
                m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = 0;
            end
        end
        for (int m = 0; m < N_MSHR; m++) ms[m] = '{0, 0, 0, 0, 0, 0, 0};
        m_hold = 0; m_hold_id = 0; exp_rsp = 0; exp_rsp_data = '0;
        golden.delete();
        mem.delete();
    endtask

    task automatic idle();
        req_valid = 0; req_we = 0; req_addr = '0; req_be = '0; req_wdata = '0;
        mem_ready = 0; rsp_valid = 0; rsp_id = '0; rsp_data = '0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1; idle();
        @(negedge clk);
        #1;
        chk({tag, "_rst_rsp_valid"}, o_rsp_valid, 0);
        chk({tag, "_rst_mem_valid"}, o_mem_req_valid, 0);
        chk({tag, "_rst_mem_we"}, o_mem_req_we, 0);
        chk({tag, "_rst_mem_id"}, o_mem_req_id, 0);
        chk({tag, "_rst_ready"}, o_req_ready, 1);
        @(negedge clk);
        rst = 0;
    endtask

    // ---------------- directed helpers ----------------
    task automatic send(input logic we, input logic [15:0] addr, input logic [3:0] be, input logic [31:0] wd);
        int n;
        n = 0;
        req_valid = 1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
        #1;
        while (!o_req_ready && n < 50) begin @(negedge clk); #1; n++; end
        if (n == 50) chk("send_timeout", 0, 1);
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic mem_take(output logic [0:0] id, output logic we, output logic [15:0] addr,
                            output logic [127:0] data);
        int n;
        n = 0;
        #1;
        while (!o_mem_req_valid && n < 50) begin @(negedge clk); #1; n++; end
        if (n == 50) chk("mem_timeout", 0, 1);
        id = o_mem_req_id; we = o_mem_req_we; addr = o_mem_req_addr; data = o_mem_req_data;
        mem_ready = 1;
        @(negedge clk);
        mem_ready = 0;
    endtask

    task automatic fill(input logic [0:0] id, input logic [127:0] data);
        rsp_valid = 1; rsp_id = id; rsp_data = data;
        @(negedge clk);
        rsp_valid = 0;
    endtask

    task automatic directed();
        logic [0:0]   id;
        logic         we;
        logic [15:0]  addr;
        logic [127:0] data;
        logic [161:0] snap;
        // cold load miss and its fill
        send(0, 16'h0010, 4'h0, 32'h0);
        chk("d1_no_rsp_on_miss", o_rsp_valid, 0);
        mem_take(id, we, addr, data);
        chk("d1_rd_id", id, 0);
        chk("d1_rd_we", we, 0);
        chk("d1_rd_addr", addr, 16'h0010);
        fill(0, {32'hD, 32'hC, 32'hB, 32'hA});
        chk("d1_fill_rsp_valid", o_rsp_valid, 1);
        chk("d1_fill_rsp_data", o_rsp_data, 32'hA);
        // a line in set 1 for later hit-under-miss
        send(0, 16'h0004, 4'h0, 32'h0);
        mem_take(id, we, addr, data);
        chk("d2_rd_addr", addr, 16'h0004);
        fill(id, {32'h44, 32'h33, 32'h22, 32'h11});
        chk("d2_fill_rsp_data", o_rsp_data, 32'h11);
        // store-hit byte merge
        send(0, 16'h0022, 4'h0, 32'h0);
        mem_take(id, we, addr, data);
        chk("d3_rd_addr", addr, 16'h0020);
        fill(id, {32'h0, 32'h11223344, 32'h0, 32'h0});
        chk("d3_fill_rsp_data", o_rsp_data, 32'h11223344);
        send(1, 16'h0022, 4'b0011, 32'h0000BEEF);
        chk("d3_store_no_rsp", o_rsp_valid, 0);
        send(0, 16'h0022, 4'h0, 32'h0);
        chk("d3_load_rsp_valid", o_rsp_valid, 1);
        chk("d3_load_rsp_data", o_rsp_data, 32'h1122BEEF);
        // dirty victim: writeback held stable under backpressure, then read
        send(1, 16'h0011, 4'hF, 32'hCAFEF00D);
        send(0, 16'h0030, 4'h0, 32'h0);
        #1;
        snap = {o_mem_req_valid, o_mem_req_we, o_mem_req_addr, o_mem_req_data, o_mem_req_id, 16'h0};
        chk("d4_wb_we", o_mem_req_we, 1);
        chk("d4_wb_addr", o_mem_req_addr, 16'h0010);
        chk("d4_wb_data", o_mem_req_data, {32'hD, 32'hC, 32'hCAFEF00D, 32'hA});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("d4_wb_stable", {o_mem_req_valid, o_mem_req_we, o_mem_req_addr, o_mem_req_data,
                                 o_mem_req_id, 16'h0}, snap);
        end
        mem_take(id, we, addr, data);
        mem_take(id, we, addr, data);
        chk("d4_rd_we", we, 0);
        chk("d4_rd_addr", addr, 16'h0030);
        // hit under miss, then same-line stall until the fill lands
        send(0, 16'h0005, 4'h0, 32'h0);
        chk("d5_hum_rsp_valid", o_rsp_valid, 1);
        chk("d5_hum_rsp_data", o_rsp_data, 32'h22);
        req_valid = 1; req_we = 0; req_addr = 16'h0031;
        #1; chk("d5_line_stall0", o_req_ready, 0);
        @(negedge clk); #1; chk("d5_line_stall1", o_req_ready, 0);
        @(negedge clk);
        rsp_valid = 1; rsp_id = id; rsp_data = {32'h3D, 32'h3C, 32'h3B, 32'h3A};
        #1; chk("d5_stall_during_fill", o_req_ready, 0);
        @(negedge clk);
        rsp_valid = 0;
        #1;
        chk("d5_miss_rsp_data", o_rsp_data, 32'h3A);
        chk("d5_ready_after_fill", o_req_ready, 1);
        @(negedge clk);
        req_valid = 0;
        chk("d5_second_rsp_data", o_rsp_data, 32'h3B);
        // reset with a read outstanding drops its fill
        send(0, 16'h0008, 4'h0, 32'h0);
        mem_take(id, we, addr, data);
        rst = 1;
        @(negedge clk); @(negedge clk);
        rst = 0;
        fill(0, {4{32'h5A5A5A5A}});
        chk("d6_dropped_fill_no_rsp", o_rsp_valid, 0);
        send(0, 16'h0005, 4'h0, 32'h0);
        chk("d6_empty_no_hit", o_rsp_valid, 0);
        #1;
        chk("d6_refetch_addr", o_mem_req_addr, 16'h0004);
    endtask

    // ---------------- random phase ----------------
    task automatic run_random(input int ncyc);
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            bit   sel_v, exp_we, hit, exp_ready, nfree, lbusy, sbusy, fill_real, new_rsp;
            int   sel, line, set, tag, hway, rid, f, v;
            logic [31:0] new_data;

            chk("rsp_valid", o_rsp_valid, exp_rsp);
            if (exp_rsp) chk("rsp_data", o_rsp_data, exp_rsp_data);
            sel_v = 0; sel = 0;
            if (m_hold) begin
                sel_v = 1; sel = m_hold_id;
            end else begin
                for (int m = N_MSHR - 1; m >= 0; m--)
                    if (ms[m].st == 1 || ms[m].st == 2) begin sel_v = 1; sel = m; end
            end
            chk("mem_valid", o_mem_req_valid, sel_v);
            exp_we = sel_v && ms[sel].st == 1;
            if (sel_v) begin
                chk("mem_id", o_mem_req_id, sel);
                chk("mem_we", o_mem_req_we, exp_we);
                chk("mem_addr", o_mem_req_addr, (exp_we ? ms[sel].vline : ms[sel].line) * 4);
                if (exp_we) chk("wb_data", o_mem_req_data, gline(ms[sel].vline));
            end

            req_valid = ($urandom_range(0, 99) < 60);
            req_we    = $urandom_range(0, 1);
            req_addr  = 16'(($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
            req_be    = 4'($urandom_range(0, 15));
            req_wdata = $urandom();
            mem_ready = ($urandom_range(0, 99) < 50);
            rsp_valid = ($urandom_range(0, 99) < 20);
            rid       = $urandom_range(0, N_MSHR - 1);
            rsp_id    = 1'(rid);
            rsp_data  = (ms[rid].st == 3) ? mline(ms[rid].line)
                                          : {$urandom(), $urandom(), $urandom(), $urandom()};
            #1;

            line = int'(req_addr) >> 2; set = line % N_SETS; tag = line / N_SETS;
            hit = 0; hway = 0;
            for (int w = 0; w < N_WAYS; w++)
                if (m_valid[set][w] && m_tag[set][w] == tag) begin hit = 1; hway = w; end
            nfree = 0; lbusy = 0; sbusy = 0;
            for (int m = 0; m < N_MSHR; m++) begin
                if (ms[m].st == 0) nfree = 1;
                else begin
                    if (ms[m].line == line) lbusy = 1;
                    if (ms[m].set == set) sbusy = 1;
                end
            end
            exp_ready = !(rsp_valid || (!hit && !nfree) || lbusy || (!hit && sbusy));
            chk("req_ready", o_req_ready, exp_ready);

            new_rsp = 0; new_data = '0;
            fill_real = rsp_valid && ms[rid].st == 3;
            if (fill_real) begin
                m_valid[ms[rid].set][ms[rid].way] = 1;
                m_dirty[ms[rid].set][ms[rid].way] = ms[rid].we;
                m_tag[ms[rid].set][ms[rid].way]   = ms[rid].line / N_SETS;
                if (!ms[rid].we) begin new_rsp = 1; new_data = gget(ms[rid].addr); end
                ms[rid].st = 0;
            end
            if (req_valid && exp_ready) begin
                if (req_we) golden[int'(req_addr)] = merge(gget(int'(req_addr)), req_be, req_wdata);
                if (hit) begin
                    if (req_we) m_dirty[set][hway] = 1;
                    else begin new_rsp = 1; new_data = gget(int'(req_addr)); end
                end else begin
                    f = 0;
                    for (int m = N_MSHR - 1; m >= 0; m--) if (ms[m].st == 0) f = m;
                    v = m_rr[set];
                    ms[f] = '{(m_valid[set][v] && m_dirty[set][v]) ? 1 : 2, line,
                              m_tag[set][v] * N_SETS + set, set, v, req_we, int'(req_addr)};
                    m_valid[set][v] = 0;
                    m_rr[set] = (v + 1) % N_WAYS;
                end
            end
            if (sel_v && mem_ready) begin
                if (exp_we) begin
                    for (int e = 0; e < 4; e++) mem[ms[sel].vline * 4 + e] = gget(ms[sel].vline * 4 + e);
                    ms[sel].st = 2;
                end else begin
                    ms[sel].st = 3;
                end
            end
            m_hold = sel_v && !mem_ready;
            m_hold_id = sel;
            exp_rsp = new_rsp;
            exp_rsp_data = new_data;
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        rst = 1;
        idle();
        chk("pin_model_merge", 128'(merge(32'h11223344, 4'b0011, 32'h0000BEEF)), 128'h1122BEEF);
        do_reset("d");
        directed();
        do_reset("r");
        model_reset();
        run_random(4000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
